fp_multiplier_seq: RTL and testbench
====================================

Name: fp_multiplier_seq

Overview:
- Sequential IEEE-754 single-precision multiplier. It is the inverse-operation companion to the ALU's divider.
- Computes A×B using a radix-2 shift-add mantissa core: one partial-product bit per clock.
- Sits in ALU_master beside the divider and shares its flag semantics: `exception` for overflow, underflow or invalid; truncation rounding; denormals flushed to zero.
- Start/done handshake with fixed latency, so the ALU sequencer can schedule it blindly.

Parameters:
- EXP_W, 8, exponent field width
- FRAC_W, 23, stored fraction width (mantissa = FRAC_W+1 with hidden 1)
- BIAS, 127, exponent bias

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- A  input  32  multiplicand, IEEE-754
- B  input  32  multiplier, IEEE-754
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; out/exception valid
- out  output  32  IEEE-754 product, held until next done
- exception  output  1  overflow/underflow/invalid/inf-operand flag, held with out

Behaviour:
- Reset (reset_n=0, async): state=IDLE; out=0, exception=0, done=0, busy=0; counter and accumulator cleared. Reset mid-operation aborts it with no done pulse. After release the block is in IDLE.
- States:
  - IDLE -> MUL on start=1. A and B are latched at that edge (edge k); busy=1 from edge k.
  - MUL: 24 cycles (edges k+1..k+24), counter 0..23. Each cycle: if mB[0], acc += mA<<cnt; mB>>=1.
  - NORM -> DONE: result registered at edge k+25.
  - DONE: done=1 for exactly that cycle; busy drops at edge k+26; return to IDLE.
- Latency is fixed at 25 edges from accepting edge to done, for every input including special cases. Special cases still traverse MUL; the result is overridden in NORM.
- Handshake edge cases:
  - start while busy=1 is ignored (no queueing).
  - start in the DONE cycle is ignored.
  - Back-to-back issue: start sampled in the IDLE cycle after done.
- Field decode:
  - sign = A[31]^B[31].
  - eA/eB = [30:23].
  - mX = {1, frac}, unless eX==0, in which case the operand is zero (denormal flush).
- Exponent: e = eA + eB - BIAS in signed 10-bit arithmetic; no wrap.
- Normalize the 48-bit product p:
  - if p[47]: frac = p[46:24], e += 1;
  - else: frac = p[45:23].
  - Truncate; no rounding.
- Result priority, applied in NORM:
  1. Either exp==255 and the other operand is zero (exp==0): out=32'h7FC00000, exception=1.
  2. Either exp==255: out={sign,8'hFF,0}, exception=1. Inf and NaN inputs are both treated as infinity.
  3. Either operand zero/denormal: out={sign,31'b0}, exception=0.
  4. e >= 255: out={sign,8'hFF,0}, exception=1.
  5. e <= 0: out={sign,31'b0}, exception=1.
  6. Otherwise: out={sign,e[7:0],frac}, exception=0.

Decomposition:
- Package fp_pkg: EXP_W, FRAC_W, BIAS, QNAN=32'h7FC00000, EXP_MAX=8'hFF, and the state enum {IDLE,MUL,NORM,DONE}. The divider and future units share this package.
- Sub-module fp_mant_mul_seq: 24-bit shift-add core with load/step/product ports. The top module owns the FSM, exponent, special cases and output registers.

Test Plan:
- 0x40000000 × 0x40400000 (2×3): start at edge k -> done pulse exactly at edge k+25, out=0x40C00000, exception=0, busy high k..k+25.
- 0x3FC00000 × 0x3FC00000 (1.5²): out=0x40100000 (normalize path, p[47]=1). Then 0xC0000000 × 0x3F000000: out=0xBF800000, exception=0.
- Overflow 0x7F000000 × 0x7F000000 -> 0x7F800000, exception=1. Underflow 0x00800000 × 0x00800000 -> 0x00000000, exception=1.
- Special cases:
  - 0x00000000 × 0x7F800000 -> 0x7FC00000, exception=1.
  - 0x80000000 × 0x40000000 -> 0x80000000, exception=0.
  - 0x7F800000 × 0xC0000000 -> 0xFF800000, exception=1.
- Handshake: start held high through an operation -> exactly one done per accepted start; operands changed mid-MUL do not affect the result.
- Reset: reset_n pulsed low at cycle k+10 -> no done, outputs 0 immediately (async). A new start after release yields the correct result at +25.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the ALU floating-point units (multiplier, divider).
// Field widths, special encodings, the sequencer state type and operand unpacking.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;
    localparam int CNT_W  = 5;

    localparam logic [31:0]       QNAN     = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0]  EXP_MAX  = 8'hFF;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MANT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } fp_state_e;

    // Denormals are flushed: a zero exponent yields a zero mantissa.
    function automatic logic [MANT_W-1:0] unpack_mant(input logic [31:0] x);
        if (x[FRAC_W+EXP_W-1:FRAC_W] == '0)
            return '0;
        return {1'b1, x[FRAC_W-1:0]};
    endfunction

endpackage

// File: rtl/fp_mant_mul_seq.sv
// Radix-2 shift-add mantissa multiplier: one multiplier bit retired per step.
// Only the top MANT_W+1 product bits are exported; lower bits are truncated away.
module fp_mant_mul_seq
    import fp_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [MANT_W-1:0] ma_i,
    input  logic [MANT_W-1:0] mb_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [MANT_W:0]   product_o
);

    logic [MANT_W-1:0] ma_q, ma_d;
    logic [MANT_W-1:0] mb_q, mb_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        ma_d  = ma_q;
        mb_d  = mb_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load_i) begin
            ma_d  = ma_i;
            mb_d  = mb_i;
            acc_d = '0;
            cnt_d = '0;
        end else if (step_i) begin
            if (mb_q[0])
                acc_d = acc_q + (PROD_W'(ma_q) << cnt_q);
            mb_d  = mb_q >> 1;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ma_q  <= '0;
            mb_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            ma_q  <= ma_d;
            mb_q  <= mb_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign product_o = acc_q[PROD_W-1:FRAC_W];

endmodule

// File: rtl/fp_multiplier_seq.sv
// Sequential single-precision multiplier with fixed 25-cycle start-to-done latency.
// Truncating, denormals flushed; exception flags overflow/underflow/invalid/inf operands.
module fp_multiplier_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        exception
);

    localparam int                E_W   = EXP_W + 2;
    localparam logic signed [E_W-1:0] BIAS_S = E_W'(BIAS);
    localparam logic signed [E_W-1:0] E_OVF  = E_W'(255);

    fp_state_e state_q, state_d;

    logic              load, step;
    logic              sign_q;
    logic [EXP_W-1:0]  ea_q, eb_q;
    logic [31:0]       out_q, out_d;
    logic              exc_q, exc_d;
    logic [CNT_W-1:0]  cnt;
    logic [MANT_W:0]   ptop;

    // Returns {exception, result}; ptop holds product bits [47:23].
    function automatic logic [32:0] pack_result(
        input logic             s,
        input logic [EXP_W-1:0] ea,
        input logic [EXP_W-1:0] eb,
        input logic [MANT_W:0]  p
    );
        logic signed [E_W-1:0] e;
        logic [FRAC_W-1:0]     frac;
        logic                  a_inf, b_inf, a_zero, b_zero;
        a_inf  = (ea == EXP_MAX);
        b_inf  = (eb == EXP_MAX);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
        if (p[MANT_W]) begin
            frac = p[MANT_W-1:1];
            e    = e + E_W'(1);
        end else begin
            frac = p[MANT_W-2:0];
        end
        if ((a_inf && b_zero) || (b_inf && a_zero))
            return {1'b1, QNAN};
        if (a_inf || b_inf)
            return {1'b1, s, EXP_MAX, {FRAC_W{1'b0}}};
        if (a_zero || b_zero)
            return {1'b0, s, 31'b0};
        if (e >= E_OVF)
            return {1'b1, s, EXP_MAX, {FRAC_W{1'b0}}};
        if (e <= E_W'(0))
            return {1'b1, s, 31'b0};
        return {1'b0, s, e[EXP_W-1:0], frac};
    endfunction

    fp_mant_mul_seq u_mant (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .load_i    (load),
        .step_i    (step),
        .ma_i      (unpack_mant(A)),
        .mb_i      (unpack_mant(B)),
        .cnt_o     (cnt),
        .product_o (ptop)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        out_d   = out_q;
        exc_d   = exc_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                step = 1'b1;
                if (cnt == CNT_LAST)
                    state_d = NORM;
            end
            // Special cases ride through MUL so latency never depends on the data.
            NORM: begin
                {exc_d, out_d} = pack_result(sign_q, ea_q, eb_q, ptop);
                state_d        = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_q <= 1'b0;
            ea_q   <= '0;
            eb_q   <= '0;
            out_q  <= '0;
            exc_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            exc_q <= exc_d;
            if (load) begin
                sign_q <= A[31] ^ B[31];
                ea_q   <= A[30:23];
                eb_q   <= B[30:23];
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out       = out_q;
    assign exception = exc_q;

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Directed bench for fp_multiplier_seq: products, special cases, handshake and reset.
module tb_fp_multiplier_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] A, B;
    logic        busy, done, exception;
    logic [31:0] out;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fp_multiplier_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .exception (exception)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issues one operation, scrambles the operand inputs after acceptance,
    // and checks latency, result and the busy/done envelope.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eo, input logic ee, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_k"}, 32'(busy), 32'd1);
        A = 32'hFFFF_FFFF;
        B = 32'h1234_5678;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd25);
        chk({tag, "_out"}, out, eo);
        chk({tag, "_exc"}, 32'(exception), 32'(ee));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int dn;
        reset_n = 1'b0;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out",  out, 32'h0);
        chk("rst_exc",  32'(exception), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, "2x3");
        run_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, "1p5sq");
        run_op(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 1'b0, "m2xhalf");
        run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, "ovf");
        run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b1, "udf");
        run_op(32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b1, "zero_inf");
        run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, "negzero");
        run_op(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1'b1, "inf_m2");

        // start held high through the whole operation, including the DONE cycle
        n  = 0;
        dn = 0;
        @(negedge clk);
        A = 32'h4000_0000;
        B = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        A = 32'h3F80_0000;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done) dn++;
        chk("hold_lat", 32'(n), 32'd25);
        chk("hold_out", out, 32'h40C0_0000);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hold_busy_after", 32'(busy), 32'd0);
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("hold_dones", 32'(dn), 32'd1);

        // asynchronous reset in the middle of MUL
        @(negedge clk);
        A = 32'h3FC0_0000;
        B = 32'h3FC0_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_out",  out, 32'h0);
        chk("arst_exc",  32'(exception), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dn = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("arst_no_done", 32'(dn), 32'd0);
        run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
